brightness_control_ctrl: RTL and testbench

BRIGHTNESS_CONTROL_CTRL -- requirements
Module: brightness_control_ctrl

---
 rtl/brightness_control_pkg.sv | 24 ++
 rtl/brightness_control_if.sv | 20 ++
 rtl/brightness_control_regs.sv | 81 ++++++++
 rtl/brightness_control_ctrl.sv | 114 +++++++++++
 tb/tb_brightness_control_ctrl.sv | 253 +++++++++++++++++++++++++
 5 files changed

// File: rtl/brightness_control_pkg.sv
// rtl/brightness_control_pkg.sv - shared register map, bit indices and FSM encodings
package brightness_control_pkg;

   localparam logic [2:0] ADDR_CTRL       = 3'd0;
   localparam logic [2:0] ADDR_STATUS     = 3'd1;
   localparam logic [2:0] ADDR_OFFSET     = 3'd2;
   localparam logic [2:0] ADDR_WIDTH      = 3'd3;
   localparam logic [2:0] ADDR_HEIGHT     = 3'd4;
   localparam logic [2:0] ADDR_INTERLACED = 3'd5;
   localparam logic [2:0] ADDR_FRAME_CNT  = 3'd6;

   localparam int CTRL_GO_BIT         = 0;
   localparam int CTRL_IRQ_EN_BIT     = 1;
   localparam int STATUS_RUNNING_BIT  = 0;
   localparam int STATUS_IRQ_PEND_BIT = 1;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      WAIT  = 2'd1,
      FRAME = 2'd2,
      STOP  = 2'd3
   } state_t;

endpackage

// File: rtl/brightness_control_if.sv
// rtl/brightness_control_if.sv - Avalon-MM register bus bundle
interface brightness_control_if;

   logic [2:0]  av_address;
   logic        av_write;
   logic [31:0] av_writedata;
   logic        av_read;
   logic [31:0] av_readdata;

   modport master (
      output av_address, av_write, av_writedata, av_read,
      input  av_readdata
   );

   modport slave (
      input  av_address, av_write, av_writedata, av_read,
      output av_readdata
   );

endinterface

// File: rtl/brightness_control_regs.sv
// rtl/brightness_control_regs.sv - register decode, read mux and irq_pend W1C
module brightness_control_regs
   import brightness_control_pkg::*;
#(
   parameter int OFFSET_WIDTH = 9
) (
   input  logic                    clk,
   input  logic                    rst,
   brightness_control_if.slave     bus,
   input  logic                    running,
   input  logic                    irq_pend_set,
   input  logic [15:0]             width,
   input  logic [15:0]             height,
   input  logic [3:0]              interlaced,
   input  logic [15:0]             frame_cnt,
   output logic                    go,
   output logic                    go_next,
   output logic                    irq_en,
   output logic                    irq_pend,
   output logic [OFFSET_WIDTH-1:0] shadow_offset
);

   logic        ctrl_wr;
   logic        status_wr;
   logic        offset_wr;
   logic [31:0] rd_mux;
   logic        unused_wdata;

   assign ctrl_wr   = bus.av_write && (bus.av_address == ADDR_CTRL);
   assign status_wr = bus.av_write && (bus.av_address == ADDR_STATUS);
   assign offset_wr = bus.av_write && (bus.av_address == ADDR_OFFSET);

   // The FSM sees a go write on the same edge the register takes it
   assign go_next = ctrl_wr ? bus.av_writedata[CTRL_GO_BIT] : go;

   assign unused_wdata = ^bus.av_writedata;

   always_comb begin
      rd_mux = '0;
      case (bus.av_address)
         ADDR_CTRL: begin
            rd_mux[CTRL_GO_BIT]     = go;
            rd_mux[CTRL_IRQ_EN_BIT] = irq_en;
         end
         ADDR_STATUS: begin
            rd_mux[STATUS_RUNNING_BIT]  = running;
            rd_mux[STATUS_IRQ_PEND_BIT] = irq_pend;
         end
         ADDR_OFFSET:     rd_mux[OFFSET_WIDTH-1:0] = shadow_offset;
         ADDR_WIDTH:      rd_mux[15:0] = width;
         ADDR_HEIGHT:     rd_mux[15:0] = height;
         ADDR_INTERLACED: rd_mux[3:0]  = interlaced;
         ADDR_FRAME_CNT:  rd_mux[15:0] = frame_cnt;
         default:         rd_mux = '0;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         go              <= 1'b0;
         irq_en          <= 1'b0;
         irq_pend        <= 1'b0;
         shadow_offset   <= '0;
         bus.av_readdata <= '0;
      end else begin
         if (ctrl_wr) begin
            go     <= bus.av_writedata[CTRL_GO_BIT];
            irq_en <= bus.av_writedata[CTRL_IRQ_EN_BIT];
         end
         if (offset_wr)
            shadow_offset <= bus.av_writedata[OFFSET_WIDTH-1:0];
         // A new event outranks a simultaneous clear
         if (irq_pend_set)
            irq_pend <= 1'b1;
         else if (status_wr && bus.av_writedata[STATUS_IRQ_PEND_BIT])
            irq_pend <= 1'b0;
         bus.av_readdata <= bus.av_read ? rd_mux : 32'd0;
      end
   end

endmodule

// File: rtl/brightness_control_ctrl.sv
// rtl/brightness_control_ctrl.sv - frame-synchronous brightness offset controller
module brightness_control_ctrl
   import brightness_control_pkg::*;
#(
   parameter int OFFSET_WIDTH = 9
) (
   input  logic                           clk,
   input  logic                           rst,
   input  logic [2:0]                     av_address,
   input  logic                           av_write,
   input  logic [31:0]                    av_writedata,
   input  logic                           av_read,
   output logic [31:0]                    av_readdata,
   input  logic                           frame_sop,
   input  logic                           frame_eop,
   input  logic [15:0]                    im_width,
   input  logic [15:0]                    im_height,
   input  logic [3:0]                     im_interlaced,
   output logic                           enable,
   output logic signed [OFFSET_WIDTH-1:0] offset_active,
   output logic                           irq
);

   brightness_control_if bus ();

   state_t                  state;
   state_t                  next_state;
   logic                    go;
   logic                    go_next;
   logic                    irq_en;
   logic                    irq_pend;
   logic [OFFSET_WIDTH-1:0] shadow_offset;
   logic [15:0]             width;
   logic [15:0]             height;
   logic [3:0]              interlaced;
   logic [15:0]             frame_cnt;
   logic                    commit;
   logic                    count_evt;

   assign bus.av_address   = av_address;
   assign bus.av_write     = av_write;
   assign bus.av_writedata = av_writedata;
   assign bus.av_read      = av_read;
   assign av_readdata      = bus.av_readdata;

   brightness_control_regs #(
      .OFFSET_WIDTH (OFFSET_WIDTH)
   ) u_regs (
      .clk           (clk),
      .rst           (rst),
      .bus           (bus),
      .running       (state != IDLE),
      .irq_pend_set  (count_evt && irq_en),
      .width         (width),
      .height        (height),
      .interlaced    (interlaced),
      .frame_cnt     (frame_cnt),
      .go            (go),
      .go_next       (go_next),
      .irq_en        (irq_en),
      .irq_pend      (irq_pend),
      .shadow_offset (shadow_offset)
   );

   assign commit    = (state == WAIT) && frame_sop;
   // A committed frame ends either on a single-beat packet or on eop after it started
   assign count_evt = (commit && frame_eop) ||
                      (((state == FRAME) || (state == STOP)) && frame_eop);
   assign irq       = irq_pend && irq_en;

   always_comb begin
      next_state = state;
      case (state)
         IDLE:  next_state = go_next ? WAIT : IDLE;
         WAIT: begin
            if (frame_sop && !frame_eop) next_state = FRAME;
            else                         next_state = go_next ? WAIT : IDLE;
         end
         FRAME: begin
            if (frame_eop) next_state = go_next ? WAIT : IDLE;
            else           next_state = go_next ? FRAME : STOP;
         end
         STOP: begin
            if (frame_eop) next_state = IDLE;
            else           next_state = go_next ? FRAME : STOP;
         end
         default: next_state = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state         <= IDLE;
         enable        <= 1'b0;
         offset_active <= '0;
         width         <= '0;
         height        <= '0;
         interlaced    <= '0;
         frame_cnt     <= '0;
      end else begin
         state  <= next_state;
         enable <= (next_state != IDLE);
         if (commit) begin
            offset_active <= shadow_offset;
            width         <= im_width;
            height        <= im_height;
            interlaced    <= im_interlaced;
         end
         if (count_evt)
            frame_cnt <= frame_cnt + 16'd1;
      end
   end

endmodule

// File: tb/tb_brightness_control_ctrl.sv
// tb/tb_brightness_control_ctrl.sv - directed self-checking bench for brightness_control_ctrl
module tb_brightness_control_ctrl;

   localparam int OW = 9;

   logic                 clk = 1'b0;
   logic                 rst;
   logic                 frame_sop;
   logic                 frame_eop;
   logic [15:0]          im_width;
   logic [15:0]          im_height;
   logic [3:0]           im_interlaced;
   logic                 enable;
   logic signed [OW-1:0] offset_active;
   logic                 irq;

   int n_checks = 0;
   int n_fail   = 0;

   brightness_control_if bus ();

   brightness_control_ctrl #(.OFFSET_WIDTH(OW)) dut (
      .clk           (clk),
      .rst           (rst),
      .av_address    (bus.av_address),
      .av_write      (bus.av_write),
      .av_writedata  (bus.av_writedata),
      .av_read       (bus.av_read),
      .av_readdata   (bus.av_readdata),
      .frame_sop     (frame_sop),
      .frame_eop     (frame_eop),
      .im_width      (im_width),
      .im_height     (im_height),
      .im_interlaced (im_interlaced),
      .enable        (enable),
      .offset_active (offset_active),
      .irq           (irq)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic        do_write;
      logic [2:0]  addr;
      logic [31:0] wdata;
      logic [31:0] exp_read;
   } vec_t;

   vec_t vecs [10];

   task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%08h expected 0x%08h", name, got, exp);
      end
   endtask

   task automatic wr(input logic [2:0] addr, input logic [31:0] data);
      @(negedge clk);
      bus.av_address   = addr;
      bus.av_writedata = data;
      bus.av_write     = 1'b1;
      @(negedge clk);
      bus.av_write     = 1'b0;
   endtask

   task automatic rd(input logic [2:0] addr, output logic [31:0] data);
      @(negedge clk);
      bus.av_address = addr;
      bus.av_read    = 1'b1;
      @(negedge clk);
      bus.av_read    = 1'b0;
      data           = bus.av_readdata;
   endtask

   task automatic pulse(input logic sop, input logic eop);
      @(negedge clk);
      frame_sop = sop;
      frame_eop = eop;
      @(negedge clk);
      frame_sop = 1'b0;
      frame_eop = 1'b0;
   endtask

   task automatic check_reg(input string name, input logic [2:0] addr, input logic [31:0] exp);
      logic [31:0] d;
      rd(addr, d);
      check(name, d, exp);
   endtask

   task automatic check_all_zero(input string tag);
      for (int a = 0; a < 8; a++) begin
         logic [2:0] aa;
         aa = a[2:0];
         check($sformatf("%s_reg%0d", tag, a), bus.av_readdata & 32'h0, 32'h0);
         check_reg($sformatf("%s_rd%0d", tag, a), aa, 32'h0);
      end
   endtask

   initial begin
      rst              = 1'b1;
      frame_sop        = 1'b0;
      frame_eop        = 1'b0;
      im_width         = 16'd640;
      im_height        = 16'd480;
      im_interlaced    = 4'h3;
      bus.av_address   = 3'd0;
      bus.av_write     = 1'b0;
      bus.av_writedata = 32'd0;
      bus.av_read      = 1'b0;

      vecs[0] = '{1'b1, 3'd2, 32'hFFFF_FFFF, 32'h0000_01FF};
      vecs[1] = '{1'b1, 3'd2, 32'h0000_0020, 32'h0000_0020};
      vecs[2] = '{1'b1, 3'd3, 32'h0000_1234, 32'h0000_0000};
      vecs[3] = '{1'b1, 3'd4, 32'h0000_0005, 32'h0000_0000};
      vecs[4] = '{1'b1, 3'd5, 32'h0000_0005, 32'h0000_0000};
      vecs[5] = '{1'b1, 3'd6, 32'h0000_0007, 32'h0000_0000};
      vecs[6] = '{1'b1, 3'd7, 32'h0000_FFFF, 32'h0000_0000};
      vecs[7] = '{1'b1, 3'd0, 32'h0000_0002, 32'h0000_0002};
      vecs[8] = '{1'b0, 3'd1, 32'h0000_0000, 32'h0000_0000};
      vecs[9] = '{1'b1, 3'd0, 32'h0000_0000, 32'h0000_0000};

      repeat (3) @(negedge clk);
      check("rst_enable", {31'd0, enable}, 32'd0);
      check("rst_irq", {31'd0, irq}, 32'd0);
      check("rst_readdata", bus.av_readdata, 32'd0);
      rst = 1'b0;

      for (int a = 0; a < 8; a++) begin
         logic [2:0] aa;
         aa = a[2:0];
         check_reg($sformatf("reset_rd%0d", a), aa, 32'h0);
      end
      check("reset_offset_active", {23'd0, offset_active}, 32'd0);

      foreach (vecs[i]) begin
         if (vecs[i].do_write) wr(vecs[i].addr, vecs[i].wdata);
         check_reg($sformatf("vec%0d_addr%0d", i, vecs[i].addr), vecs[i].addr, vecs[i].exp_read);
      end
      check("vec_enable_idle", {31'd0, enable}, 32'd0);

      // start and first commit
      check("pre_go_enable", {31'd0, enable}, 32'd0);
      wr(3'd0, 32'h1);
      check("go_enable", {31'd0, enable}, 32'd1);
      check_reg("go_running", 3'd1, 32'h1);
      pulse(1'b1, 1'b0);
      check("commit_offset", {23'd0, offset_active}, 32'h020);
      check_reg("commit_width", 3'd3, 32'd640);
      check_reg("commit_height", 3'd4, 32'd480);
      check_reg("commit_interlaced", 3'd5, 32'h3);

      // mid-frame write and geometry change are held off
      wr(3'd2, 32'h1F0);
      im_width = 16'd800;
      check("midframe_offset", {23'd0, offset_active}, 32'h020);
      check_reg("midframe_width", 3'd3, 32'd640);
      pulse(1'b0, 1'b1);
      check("eop_offset_held", {23'd0, offset_active}, 32'h020);
      check_reg("eop_frame_cnt", 3'd6, 32'd1);
      pulse(1'b1, 1'b0);
      check("second_commit_offset", {23'd0, offset_active}, 32'h1F0);
      check_reg("second_commit_width", 3'd3, 32'd800);

      // graceful stop
      wr(3'd0, 32'h0);
      check("stop_enable", {31'd0, enable}, 32'd1);
      check_reg("stop_running", 3'd1, 32'h1);
      pulse(1'b0, 1'b1);
      check("stopped_enable", {31'd0, enable}, 32'd0);
      check_reg("stopped_running", 3'd1, 32'h0);
      check_reg("stopped_frame_cnt", 3'd6, 32'd2);

      // sop while idle is not a commit
      wr(3'd2, 32'h055);
      pulse(1'b1, 1'b0);
      check("idle_sop_offset", {23'd0, offset_active}, 32'h1F0);
      check_reg("idle_sop_running", 3'd1, 32'h0);

      // interrupt, set beats a simultaneous clear
      wr(3'd0, 32'h3);
      pulse(1'b0, 1'b1);
      check_reg("wait_eop_ignored", 3'd6, 32'd2);
      pulse(1'b1, 1'b0);
      check("irq_commit_offset", {23'd0, offset_active}, 32'h055);
      check("irq_before_eop", {31'd0, irq}, 32'd0);
      pulse(1'b0, 1'b1);
      check("irq_after_eop", {31'd0, irq}, 32'd1);
      check_reg("irq_frame_cnt", 3'd6, 32'd3);
      pulse(1'b1, 1'b0);
      @(negedge clk);
      bus.av_address   = 3'd1;
      bus.av_writedata = 32'h2;
      bus.av_write     = 1'b1;
      frame_eop        = 1'b1;
      @(negedge clk);
      bus.av_write     = 1'b0;
      frame_eop        = 1'b0;
      check("irq_set_wins", {31'd0, irq}, 32'd1);
      check_reg("set_wins_frame_cnt", 3'd6, 32'd4);
      wr(3'd0, 32'h3);
      check("ctrl_write_keeps_irq", {31'd0, irq}, 32'd1);
      wr(3'd1, 32'h2);
      check("irq_w1c", {31'd0, irq}, 32'd0);
      check_reg("irq_w1c_status", 3'd1, 32'h1);

      // single-beat frame counts once and stays in WAIT
      wr(3'd2, 32'h0AA);
      pulse(1'b1, 1'b1);
      check("single_beat_offset", {23'd0, offset_active}, 32'h0AA);
      check("single_beat_enable", {31'd0, enable}, 32'd1);
      check_reg("single_beat_cnt", 3'd6, 32'd5);
      check_reg("single_beat_irq", 3'd1, 32'h3);

      // back-to-back single-beat frames carry the counter through its wrap
      @(negedge clk);
      frame_sop = 1'b1;
      frame_eop = 1'b1;
      repeat (65531) @(negedge clk);
      frame_sop = 1'b0;
      frame_eop = 1'b0;
      check_reg("wrap_frame_cnt", 3'd6, 32'd0);

      // reset mid-frame abandons the frame
      pulse(1'b1, 1'b0);
      check("preset_enable", {31'd0, enable}, 32'd1);
      @(negedge clk);
      rst = 1'b1;
      @(negedge clk);
      check("midrst_enable", {31'd0, enable}, 32'd0);
      check("midrst_irq", {31'd0, irq}, 32'd0);
      check("midrst_offset", {23'd0, offset_active}, 32'd0);
      rst = 1'b0;
      check_all_zero("post_rst");
      pulse(1'b0, 1'b1);
      check_reg("post_rst_eop_cnt", 3'd6, 32'd0);
      check("post_rst_irq", {31'd0, irq}, 32'd0);
      wr(3'd2, 32'h033);
      pulse(1'b1, 1'b0);
      check("post_rst_no_go_commit", {23'd0, offset_active}, 32'd0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

   initial begin
      #2_000_000;
      $display("FAIL timeout: simulation exceeded time limit");
      $fatal(1, "timeout");
   end

endmodule
